// File: rtl/mips_instr_encoder_pkg.sv
// Purpose: shared MIPS ISA constants for the instruction encoder (opcodes, JR funct, kind codes, FSM states).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_isa_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    // Instruction kinds; identical to the control unit's ALUOp codes
    localparam logic [3:0] KIND_ADDI  = 4'd1;
    localparam logic [3:0] KIND_ORI   = 4'd2;
    localparam logic [3:0] KIND_ANDI  = 4'd3;
    localparam logic [3:0] KIND_LUI   = 4'd4;
    localparam logic [3:0] KIND_SW    = 4'd5;
    localparam logic [3:0] KIND_LW    = 4'd6;
    localparam logic [3:0] KIND_BEQ   = 4'd7;
    localparam logic [3:0] KIND_BNE   = 4'd8;
    localparam logic [3:0] KIND_J     = 4'd9;
    localparam logic [3:0] KIND_JAL   = 4'd10;
    localparam logic [3:0] KIND_RTYPE = 4'd15;

    // Loader FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // One instruction beat as presented by the sequencer
    typedef struct packed {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } beat_t;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Purpose: sequencer <-> encoder bundle: start, beat handshake and fields, memory write port and status.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the encoder (slave) gates in_valid from the sequencer (master).
interface mips_instr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            kind;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [15:0]           imm;
    logic [25:0]           target;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  err;

    modport master (
        output start, in_valid, kind, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    modport slave (
        input  start, in_valid, kind, rs, rt, rd, shamt, funct, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/mips_instr_encoder_pack.sv
// Purpose: pack one instruction beat into a 32-bit MIPS word; legal=0 for unassigned kinds.
// Latency: combinational.
// Backpressure: none.
// Ports: beat (kind + operand fields) in; word (encoded instruction), legal out.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  beat_t       beat,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (beat.kind)
            // JR only carries rs; whatever the sequencer left in rt/rd/shamt is dropped
            KIND_RTYPE: word = (beat.funct == FUNCT_JR)
                             ? {OP_RTYPE, beat.rs, 15'd0, beat.funct}
                             : {OP_RTYPE, beat.rs, beat.rt, beat.rd, beat.shamt, beat.funct};
            KIND_ADDI:  word = {OP_ADDI, beat.rs, beat.rt, beat.imm};
            KIND_ORI:   word = {OP_ORI,  beat.rs, beat.rt, beat.imm};
            KIND_ANDI:  word = {OP_ANDI, beat.rs, beat.rt, beat.imm};
            KIND_SW:    word = {OP_SW,   beat.rs, beat.rt, beat.imm};
            KIND_LW:    word = {OP_LW,   beat.rs, beat.rt, beat.imm};
            KIND_BEQ:   word = {OP_BEQ,  beat.rs, beat.rt, beat.imm};
            KIND_BNE:   word = {OP_BNE,  beat.rs, beat.rt, beat.imm};
            KIND_LUI:   word = {OP_LUI,  5'd0,    beat.rt, beat.imm};
            KIND_J:     word = {OP_J,    beat.target};
            KIND_JAL:   word = {OP_JAL,  beat.target};
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Purpose: program loader; encodes accepted beats and writes them to consecutive instruction-memory words.
// Latency: 1 cycle from accepting edge to mem_we/mem_addr/mem_wdata; count/full/err update on that same edge.
// Backpressure: in_ready only in LOAD and never while start is high; drops once the region is full.
// Ports: clk, reset (async, active-low), bus (slave side of mips_instr_encoder_if).
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
)(
    input  logic                  clk,
    input  logic                  reset,
    mips_instr_encoder_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  full_q;
    logic                  err_q;

    beat_t       beat;
    logic [31:0] word;
    logic        legal;
    logic        accept;

    assign beat = '{kind:   bus.kind,   rs:    bus.rs,    rt:  bus.rt,
                    rd:     bus.rd,     shamt: bus.shamt, funct: bus.funct,
                    imm:    bus.imm,    target: bus.target};

    mips_instr_pack u_pack (
        .beat  (beat),
        .word  (word),
        .legal (legal)
    );

    assign bus.in_ready = (state == ST_LOAD) && !bus.start;
    assign accept       = bus.in_valid && bus.in_ready;
    assign count_inc    = count_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            next_addr   <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (bus.start) begin
                state     <= ST_LOAD;
                next_addr <= BASE;
                count_q   <= '0;
                full_q    <= 1'b0;
                err_q     <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= next_addr;
                    mem_wdata_q <= word;
                    next_addr   <= next_addr + 1'b1;
                    count_q     <= count_inc;
                    // MSB of the count set means 2^ADDR_WIDTH words written: stop, no wrap
                    if (count_inc[ADDR_WIDTH]) begin
                        full_q <= 1'b1;
                        state  <= ST_FULL;
                    end
                end else begin
                    // Illegal kind is consumed but leaves no trace except the sticky flag
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Purpose: self-checking bench for mips_instr_encoder: vector table, corner sequences, randomized model run.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_instr_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_instr_encoder_if #(.ADDR_WIDTH(8)) ifa ();
    mips_instr_encoder_if #(.ADDR_WIDTH(2)) ifb ();

    // The small instance sees exactly the same stimulus as the large one
    assign ifb.start    = ifa.start;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.kind     = ifa.kind;
    assign ifb.rs       = ifa.rs;
    assign ifb.rt       = ifa.rt;
    assign ifb.rd       = ifa.rd;
    assign ifb.shamt    = ifa.shamt;
    assign ifb.funct    = ifa.funct;
    assign ifb.imm      = ifa.imm;
    assign ifb.target   = ifa.target;

    mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
    mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (dut_a, 256-word region) ----------------
    localparam int CAP = 256;
    bit          m_open;
    bit          m_full;
    bit          m_err;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_wdata;
    int          m_next;
    int          m_count;

    task automatic model_reset();
        m_open = 0; m_full = 0; m_err = 0; m_we = 0;
        m_addr = 0; m_wdata = 32'h0; m_next = 0; m_count = 0;
    endtask

    // {legal, word} from the instruction-format rules, built arithmetically
    function automatic logic [32:0] ref_enc(input int k, input int rs, input int rt, input int rd,
                                            input int sh, input int fn, input int imm, input int tgt);
        longint unsigned w;
        int op;
        case (k)
            1: op = 'h08;  2: op = 'h0d;  3: op = 'h0c;  4: op = 'h0f;
            5: op = 'h2b;  6: op = 'h23;  7: op = 'h04;  8: op = 'h05;
            9: op = 'h02; 10: op = 'h03; 15: op = 'h00;
            default: op = -1;
        endcase
        if (op < 0) return 33'h0;
        if (k == 15) begin
            if (fn == 8) w = rs * 64'd2097152 + fn;
            else         w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + sh * 64'd64 + fn;
        end else if (k == 9 || k == 10) begin
            w = op * 64'd67108864 + tgt;
        end else if (k == 4) begin
            w = op * 64'd67108864 + rt * 64'd65536 + imm;
        end else begin
            w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
        end
        return {1'b1, w[31:0]};
    endfunction

    // One clock: called just after a negedge with inputs applied; returns at next negedge after checking
    task automatic cycle();
        logic        rdy;
        logic [32:0] e;
        #1;
        rdy = m_open && !ifa.start;
        chk("in_ready", {31'd0, ifa.in_ready}, {31'd0, rdy});
        if (ifa.start) begin
            m_open = 1; m_count = 0; m_next = 0; m_err = 0; m_full = 0; m_we = 0;
        end else if (ifa.in_valid && rdy) begin
            e = ref_enc(ifa.kind, ifa.rs, ifa.rt, ifa.rd, ifa.shamt, ifa.funct, ifa.imm, ifa.target);
            if (e[32]) begin
                m_we = 1; m_addr = m_next; m_wdata = e[31:0];
                m_next = (m_next + 1) % CAP;
                m_count++;
                if (m_count == CAP) begin m_full = 1; m_open = 0; end
            end else begin
                m_we = 0; m_err = 1;
            end
        end else begin
            m_we = 0;
        end
        @(negedge clk);
        chk("mem_we",    {31'd0, ifa.mem_we},  {31'd0, m_we});
        chk("mem_addr",  {24'd0, ifa.mem_addr}, m_addr);
        chk("mem_wdata", ifa.mem_wdata, m_wdata);
        chk("count",     {23'd0, ifa.count},   m_count);
        chk("full",      {31'd0, ifa.full},    {31'd0, m_full});
        chk("err",       {31'd0, ifa.err},     {31'd0, m_err});
    endtask

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp_word;
        bit          exp_legal;
    } vec_t;

    task automatic set_beat(input vec_t v);
        ifa.kind = v.kind; ifa.rs = v.rs; ifa.rt = v.rt; ifa.rd = v.rd; ifa.shamt = v.shamt;
        ifa.funct = v.funct; ifa.imm = v.imm; ifa.target = v.target;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_we"},    {31'd0, ifa.mem_we},   0);
        chk({tag, "_a_addr"},  {24'd0, ifa.mem_addr}, 0);
        chk({tag, "_a_wdata"}, ifa.mem_wdata,         0);
        chk({tag, "_a_count"}, {23'd0, ifa.count},    0);
        chk({tag, "_a_full"},  {31'd0, ifa.full},     0);
        chk({tag, "_a_err"},   {31'd0, ifa.err},      0);
        chk({tag, "_a_rdy"},   {31'd0, ifa.in_ready}, 0);
        chk({tag, "_b_we"},    {31'd0, ifb.mem_we},   0);
        chk({tag, "_b_count"}, {29'd0, ifb.count},    0);
        chk({tag, "_b_rdy"},   {31'd0, ifb.in_ready}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[15];
        vec_t v;
        int legal_kinds[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};

        vt[0]  = '{4'd1,  5'd0,  5'd8,  5'd0, 5'd0, 6'h00, 16'h0005, 26'h0,       32'h20080005, 1'b1};
        vt[1]  = '{4'd15, 5'd9,  5'd10, 5'd8, 5'd0, 6'h20, 16'h1234, 26'h0,       32'h012A4020, 1'b1};
        vt[2]  = '{4'd6,  5'd29, 5'd8,  5'd3, 5'd0, 6'h00, 16'h0004, 26'h0,       32'h8FA80004, 1'b1};
        vt[3]  = '{4'd9,  5'd7,  5'd6,  5'd5, 5'd4, 6'h01, 16'hFFFF, 26'h0100008, 32'h08100008, 1'b1};
        vt[4]  = '{4'd15, 5'd31, 5'd5,  5'd7, 5'd3, 6'h08, 16'h0000, 26'h0,       32'h03E00008, 1'b1};
        vt[5]  = '{4'd12, 5'd1,  5'd2,  5'd3, 5'd0, 6'h00, 16'h0001, 26'h0,       32'h00000000, 1'b0};
        vt[6]  = '{4'd4,  5'd3,  5'd1,  5'd0, 5'd0, 6'h00, 16'h1234, 26'h0,       32'h3C011234, 1'b1};
        vt[7]  = '{4'd2,  5'd2,  5'd3,  5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0,       32'h3443FFFF, 1'b1};
        vt[8]  = '{4'd3,  5'd1,  5'd1,  5'd0, 5'd0, 6'h00, 16'h00FF, 26'h0,       32'h302100FF, 1'b1};
        vt[9]  = '{4'd5,  5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0,       32'hAFBF0008, 1'b1};
        vt[10] = '{4'd7,  5'd4,  5'd5,  5'd0, 5'd0, 6'h00, 16'hFFFE, 26'h0,       32'h1085FFFE, 1'b1};
        vt[11] = '{4'd8,  5'd1,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0003, 26'h0,       32'h14200003, 1'b1};
        vt[12] = '{4'd10, 5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1};
        vt[13] = '{4'd0,  5'd1,  5'd1,  5'd1, 5'd0, 6'h00, 16'h0001, 26'h0,       32'h00000000, 1'b0};
        vt[14] = '{4'd14, 5'd2,  5'd2,  5'd2, 5'd0, 6'h00, 16'h0002, 26'h0,       32'h00000000, 1'b0};

        // Reset state
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.in_valid = 1'b0;
        set_beat(vt[0]);
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // IDLE ignores beats until start
        ifa.in_valid = 1'b1;
        repeat (2) cycle();

        // Vector table, back-to-back after one start
        ifa.in_valid = 1'b0; ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            v = vt[i];
            set_beat(v);
            ifa.in_valid = 1'b1;
            cycle();
            if (v.exp_legal) begin
                chk($sformatf("tbl%0d_we", i),   {31'd0, ifa.mem_we}, 1);
                chk($sformatf("tbl%0d_word", i), ifa.mem_wdata, v.exp_word);
            end else begin
                chk($sformatf("tbl%0d_nowe", i), {31'd0, ifa.mem_we}, 0);
                chk($sformatf("tbl%0d_err", i),  {31'd0, ifa.err}, 1);
            end
        end
        ifa.in_valid = 1'b0;
        cycle();

        // Small region: 5 beats offered, 4 land, then full; start reopens
        ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        set_beat(vt[0]);
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifa.imm = 16'(i);
            #1;
            chk($sformatf("b%0d_ready", i), {31'd0, ifb.in_ready}, (i < 4) ? 1 : 0);
            cycle();
            chk($sformatf("b%0d_we", i),    {31'd0, ifb.mem_we}, (i < 4) ? 1 : 0);
            if (i < 4) chk($sformatf("b%0d_addr", i), {30'd0, ifb.mem_addr}, i);
            chk($sformatf("b%0d_count", i), {29'd0, ifb.count}, (i < 4) ? i + 1 : 4);
            chk($sformatf("b%0d_full", i),  {31'd0, ifb.full}, (i >= 3) ? 1 : 0);
        end
        chk("b_last_word", ifb.mem_wdata, 32'h20080003);
        ifa.in_valid = 1'b0; ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        #1;
        chk("b_restart_ready", {31'd0, ifb.in_ready}, 1);
        chk("b_restart_count", {29'd0, ifb.count}, 0);
        chk("b_restart_full",  {31'd0, ifb.full}, 0);
        cycle();

        // Reset right after an accepted beat: write pulse aborted asynchronously
        set_beat(vt[1]);
        ifa.in_valid = 1'b1;
        cycle();
        chk("pre_reset_we", {31'd0, ifa.mem_we}, 1);
        rst_n = 1'b0;
        ifa.in_valid = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        ifa.in_valid = 1'b1;
        repeat (2) cycle();

        // Randomized run against the model
        for (int c = 0; c < 500; c++) begin
            ifa.start    = ($urandom_range(0, 63) == 0);
            ifa.in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ifa.kind = 4'($urandom_range(0, 15));
            else                           ifa.kind = 4'(legal_kinds[$urandom_range(0, 10)]);
            ifa.rs     = 5'($urandom);
            ifa.rt     = 5'($urandom);
            ifa.rd     = 5'($urandom);
            ifa.shamt  = 5'($urandom);
            ifa.funct  = ($urandom_range(0, 9) == 0) ? 6'h08 : 6'($urandom);
            ifa.imm    = 16'($urandom);
            ifa.target = 26'($urandom);
            if (c == 0) ifa.start = 1'b1;
            cycle();
        end
        ifa.start = 1'b0; ifa.in_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
